// File: rtl/shift_add_mult.sv
// shift_add_mult: self-sequenced unsigned W x W -> 2W shift-add multiplier.
// One combined add-and-shift per clock, W iterations per product, start/done
// handshake. The (2W+1)-bit accumulator keeps the carry of each partial add.
module shift_add_mult #(
    parameter int W = 4
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Start,
    input  logic [W-1:0]   Multiplicando,
    input  logic [W-1:0]   Multiplicador,
    output logic           Busy,
    output logic           Done,
    output logic [2*W-1:0] Produto
);

    // Iteration counter only needs to reach W-1 without wrapping.
    localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*W:0]     acc_q, acc_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2*W:0]     acc_step;

    // One multiplier iteration: conditionally add the multiplicand into the
    // upper half (carry kept in the W+1-bit sum), then shift right by one.
    function automatic logic [2*W:0] add_shift(input logic [2*W:0] acc,
                                               input logic [W-1:0] mcand);
        logic [W:0] sum;
        sum = acc[2*W:W] + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        return {1'b0, sum, acc[W-1:1]};
    endfunction

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        count_d  = count_q;
        prod_d   = prod_q;
        acc_step = add_shift(acc_q, mcand_q);

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    mcand_d = Multiplicando;
                    acc_d   = {{(W+1){1'b0}}, Multiplicador};
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_step;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_ITER) begin
                    state_d = DONE;
                    prod_d  = acc_step[2*W-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered copies of the upcoming state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            count_q <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Produto = prod_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Testbench for shift_add_mult: W=4 and W=8 instances, scoreboard queues
// filled when operands are issued and drained on each Done pulse.
module tb_shift_add_mult;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       busy4, done4, busy8, done8;
    logic [7:0] prod4;
    logic [15:0] prod8;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt4 = 0;
    int done_cnt8 = 0;
    int cyc = 0;

    logic [7:0]  exp4[$];
    logic [15:0] exp8[$];

    shift_add_mult #(.W(4)) dut4 (
        .Clk(clk), .Rst(rst), .Start(start4),
        .Multiplicando(a4), .Multiplicador(b4),
        .Busy(busy4), .Done(done4), .Produto(prod4)
    );

    shift_add_mult #(.W(8)) dut8 (
        .Clk(clk), .Rst(rst), .Start(start8),
        .Multiplicando(a8), .Multiplicador(b8),
        .Busy(busy8), .Done(done8), .Produto(prod8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the W=4 instance: every Done pops one expected product.
    always @(negedge clk) begin
        logic [7:0] e;
        if (done4) begin
            done_cnt4++;
            n_cmp++;
            if (exp4.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_done4: Done=1 with no pending operation, Produto=%0d", prod4);
            end else begin
                e = exp4.pop_front();
                if (prod4 !== e) begin
                    n_fail++;
                    $display("FAIL product4: got %0d expected %0d", prod4, e);
                end
                n_cmp++;
                if (dut4.acc_q[8] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL acc_msb4: got %b expected 0", dut4.acc_q[8]);
                end
            end
        end
    end

    // Scoreboard for the W=8 instance.
    always @(negedge clk) begin
        logic [15:0] e;
        if (done8) begin
            done_cnt8++;
            n_cmp++;
            if (exp8.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_done8: Done=1 with no pending operation, Produto=%0d", prod8);
            end else begin
                e = exp8.pop_front();
                if (prod8 !== e) begin
                    n_fail++;
                    $display("FAIL product8: got %0d expected %0d", prod8, e);
                end
                n_cmp++;
                if (dut8.acc_q[16] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL acc_msb8: got %b expected 0", dut8.acc_q[16]);
                end
            end
        end
    end

    // Called right after a negedge with the W=4 DUT idle; Start is seen at the next posedge.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b);
        start4 = 1'b1;
        a4 = a;
        b4 = b;
        exp4.push_back(8'(a) * 8'(b));
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        exp8.push_back(16'(a) * 16'(b));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic drain4(input string name);
        int k;
        k = 0;
        while ((exp4.size() != 0 || busy4) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL %s_timeout4: pending=%0d busy=%b after 100 cycles, required 0/0", name, exp4.size(), busy4);
            exp4.delete();
        end
    endtask

    task automatic drain8(input string name);
        int k;
        k = 0;
        while ((exp8.size() != 0 || busy8) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL %s_timeout8: pending=%0d busy=%b after 100 cycles, required 0/0", name, exp8.size(), busy8);
            exp8.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy4, done4, prod4} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset4: busy=%b done=%b prod=%0d, required 0 0 0", busy4, done4, prod4);
        end
        n_cmp++;
        if ({busy8, done8, prod8} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset8: busy=%b done=%b prod=%0d, required 0 0 0", busy8, done8, prod8);
        end
    endtask

    // 7x5: Busy for 5 cycles after accept, Done only in the 5th, result held.
    task automatic test_basic_timing();
        logic exp_busy, exp_done;
        issue4(4'd7, 4'd5);
        for (int i = 1; i <= 7; i++) begin
            exp_busy = (i <= 5);
            exp_done = (i == 5);
            n_cmp++;
            if (busy4 !== exp_busy || done4 !== exp_done) begin
                n_fail++;
                $display("FAIL timing4 cycle %0d: busy=%b done=%b, required busy=%b done=%b", i, busy4, done4, exp_busy, exp_done);
            end
            if (i < 7) @(negedge clk);
        end
        n_cmp++;
        if (prod4 !== 8'd35) begin
            n_fail++;
            $display("FAIL hold4: Produto=%0d, required 35", prod4);
        end
        drain4("basic");
    endtask

    task automatic test_corners();
        issue4(4'd15, 4'd15);
        drain4("c15x15");
        issue4(4'd0, 4'd9);
        drain4("c0x9");
        issue4(4'd9, 4'd0);
        drain4("c9x0");
        issue4(4'd1, 4'd15);
        drain4("c1x15");
    endtask

    // Start held high: accepts repeat every W+2 cycles; Start in DONE ignored.
    task automatic test_back_to_back();
        int stamps[3];
        int seen;
        int k;
        start4 = 1'b1;
        a4 = 4'd7;
        b4 = 4'd5;
        repeat (3) exp4.push_back(8'd35);
        seen = 0;
        k = 0;
        while (seen < 3 && k < 60) begin
            @(negedge clk);
            k++;
            if (done4) begin
                stamps[seen] = cyc;
                seen++;
                if (seen == 3) start4 = 1'b0;
            end
        end
        start4 = 1'b0;
        n_cmp++;
        if (seen != 3) begin
            n_fail++;
            $display("FAIL b2b_count4: saw %0d Done pulses, required 3", seen);
        end else begin
            for (int j = 1; j < 3; j++) begin
                n_cmp++;
                if (stamps[j] - stamps[j-1] != 6) begin
                    n_fail++;
                    $display("FAIL b2b_period4: Done spacing %0d cycles, required 6", stamps[j] - stamps[j-1]);
                end
            end
        end
        drain4("b2b");
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_extra4: busy=%b after Start released, required 0", busy4);
        end
    endtask

    // Operands change during RUN must not affect the result.
    task automatic test_operand_change();
        issue4(4'd7, 4'd5);
        @(negedge clk);
        a4 = 4'd3;
        b4 = 4'd3;
        drain4("opchg");
    endtask

    // Reset at the second RUN iteration aborts with no Done; next op is clean.
    task automatic test_abort();
        start4 = 1'b1;
        a4 = 4'd13;
        b4 = 4'd11;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy4, done4, prod4} !== 10'd0) begin
            n_fail++;
            $display("FAIL abort4: busy=%b done=%b prod=%0d, required 0 0 0", busy4, done4, prod4);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (done4 !== 1'b0 || busy4 !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet4: done=%b busy=%b, required 0 0", done4, busy4);
            end
        end
        issue4(4'd13, 4'd11);
        drain4("after_abort");
    endtask

    task automatic test_w8();
        issue8(8'd255, 8'd255);
        for (int i = 1; i <= 9; i++) begin
            n_cmp++;
            if (done8 !== (i == 9)) begin
                n_fail++;
                $display("FAIL latency8 cycle %0d: done=%b, required %b", i, done8, (i == 9));
            end
            if (i < 9) @(negedge clk);
        end
        drain8("w8_255");
        issue8(8'd200, 8'd7);
        drain8("w8_200x7");
        issue8(8'd128, 8'd2);
        drain8("w8_128x2");
    endtask

    // Random operands and gaps; Start is also toggled with junk while busy.
    task automatic test_random();
        int base_done;
        int issued;
        int k;
        int gap;
        base_done = done_cnt4;
        issued = 0;
        for (int n = 0; n < 200; n++) begin
            k = 0;
            while (busy4 && k < 50) begin
                start4 = 1'($urandom_range(0, 1));
                a4 = 4'($urandom_range(0, 15));
                b4 = 4'($urandom_range(0, 15));
                @(negedge clk);
                k++;
            end
            start4 = 1'b0;
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            issue4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            issued++;
        end
        drain4("random");
        n_cmp++;
        if (done_cnt4 - base_done != issued) begin
            n_fail++;
            $display("FAIL random_done_count4: %0d Done pulses, required %0d", done_cnt4 - base_done, issued);
        end
    endtask

    initial begin
        rst = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        @(negedge clk);
        test_reset();
        test_basic_timing();
        test_corners();
        test_back_to_back();
        test_operand_change();
        test_abort();
        test_w8();
        test_random();
        n_cmp++;
        if (exp4.size() != 0 || exp8.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: pending4=%0d pending8=%0d, required 0 0", exp4.size(), exp8.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
